// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : regfile_2r1w
// Description : DEPTH x W register file with two combinational read ports
//               and one synchronous write port. Optional hard-wired zero
//               word and same-cycle write-to-read bypass. Operand store for
//               the ALU datapath (A/B operands out, ALU result in).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
  parameter int W        = 32,  // data width in bits
  parameter int ADDR_W   = 5,   // address width, DEPTH = 2**ADDR_W
  parameter int ZERO_REG = 1,   // 1: word 0 reads 0 and ignores writes
  parameter int BYPASS   = 1    // 1: read of the address being written returns wr_data
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [W-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr_a,
  output logic [W-1:0]      rd_data_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [W-1:0]      rd_data_b
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Flop array rather than an inferred memory: reset has to clear every word.
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];

  // Read logic shared by both ports. Priority: zero word, then bypass of the
  // live write inputs (never while reset is asserted), then stored contents.
  function automatic logic [W-1:0] read_word(input logic [ADDR_W-1:0] addr);
    logic [W-1:0] data;
    if ((ZERO_REG != 0) && (addr == '0)) begin
      data = '0;
    end else if ((BYPASS != 0) && wr_en && !rst && (addr == wr_addr)) begin
      data = wr_data;
    end else begin
      data = mem_q[addr];
    end
    return data;
  endfunction

  // Next-state of each word: hold, or take wr_data when addressed. Writes to
  // word 0 are dropped when it is the hard-wired zero register.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_addr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0))) begin
        mem_d[i] = wr_data;
      end
    end
  end

  // Storage update; synchronous reset wins over any write in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  // Read port A (ALU operand A).
  always_comb begin
    rd_data_a = read_word(rd_addr_a);
  end

  // Read port B (ALU operand B).
  always_comb begin
    rd_data_b = read_word(rd_addr_b);
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile_2r1w
// Description : Self-checking bench for regfile_2r1w. Three configurations
//               (zero+bypass 32x32, plain 32x32, zero+bypass 8x8) are checked
//               against array-based reference models with directed scenarios
//               followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_regfile_2r1w;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // shared reset; wide stimulus drives both 32-bit instances
  logic        rst;
  logic        we;
  logic [4:0]  wa, ra, rb;
  logic [31:0] wd;
  logic [31:0] rda_zb, rdb_zb, rda_pl, rdb_pl;
  // narrow stimulus (8-bit data, 3-bit address)
  logic        n_we;
  logic [2:0]  n_wa, n_ra, n_rb;
  logic [31:0] n_wd;
  logic [7:0]  rda_n, rdb_n;

  regfile_2r1w #(.W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut_zb (
    .clk(clk), .rst(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .rd_addr_a(ra), .rd_data_a(rda_zb), .rd_addr_b(rb), .rd_data_b(rdb_zb)
  );

  regfile_2r1w #(.W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) u_dut_pl (
    .clk(clk), .rst(rst), .wr_en(we), .wr_addr(wa), .wr_data(wd),
    .rd_addr_a(ra), .rd_data_a(rda_pl), .rd_addr_b(rb), .rd_data_b(rdb_pl)
  );

  regfile_2r1w #(.W(8), .ADDR_W(3), .ZERO_REG(1), .BYPASS(1)) u_dut_n (
    .clk(clk), .rst(rst), .wr_en(n_we), .wr_addr(n_wa), .wr_data(n_wd[7:0]),
    .rd_addr_a(n_ra), .rd_data_a(rda_n), .rd_addr_b(n_rb), .rd_data_b(rdb_n)
  );

  // reference contents
  logic [31:0] m_zb [32];
  logic [31:0] m_pl [32];
  logic [31:0] m_n  [8];

  int    n_checks = 0;
  int    n_errors = 0;
  string phase    = "init";

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s/%s: got %08h expected %08h", phase, tag, obs, exp);
    end
  endtask

  // expected reads, straight from the read rules of each configuration
  function automatic logic [31:0] exp_zb(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (we && !rst && (a == wa)) return wd;
    return m_zb[a];
  endfunction

  function automatic logic [31:0] exp_pl(input logic [4:0] a);
    return m_pl[a];
  endfunction

  function automatic logic [31:0] exp_n(input logic [2:0] a);
    if (a == 3'd0) return 32'h0;
    if (n_we && !rst && (a == n_wa)) return n_wd & 32'hFF;
    return m_n[a];
  endfunction

  // Inputs are set by the caller while clk is low. Reads are checked before
  // the edge, then the models take the edge, and control returns at negedge.
  task automatic step(input bit chk);
    #2;
    if (chk) begin
      check($sformatf("zb_a@%0d", ra), rda_zb, exp_zb(ra));
      check($sformatf("zb_b@%0d", rb), rdb_zb, exp_zb(rb));
      check($sformatf("pl_a@%0d", ra), rda_pl, exp_pl(ra));
      check($sformatf("pl_b@%0d", rb), rdb_pl, exp_pl(rb));
      check($sformatf("n_a@%0d", n_ra), {24'h0, rda_n}, exp_n(n_ra));
      check($sformatf("n_b@%0d", n_rb), {24'h0, rdb_n}, exp_n(n_rb));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_zb[i] = 32'h0;
        m_pl[i] = 32'h0;
      end
      for (int i = 0; i < 8; i++) m_n[i] = 32'h0;
    end else begin
      if (we && (wa != 5'd0)) m_zb[wa] = wd;
      if (we) m_pl[wa] = wd;
      if (n_we && (n_wa != 3'd0)) m_n[n_wa] = n_wd & 32'hFF;
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; we = 1'b0; n_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; wa = '0; wd = '0; ra = '0; rb = '0;
    n_we = 1'b0; n_wa = '0; n_wd = '0; n_ra = '0; n_rb = '0;
    step(1'b0);                       // contents undefined before first reset

    phase = "reset_state";
    idle();
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); rb = 5'(31 - a); n_ra = 3'(a); n_rb = 3'(7 - a);
      step(1'b1);
    end

    phase = "reset_clear";
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'hDEADBEEF;
      n_we = 1'b1; n_wa = 3'(i); n_wd = 32'h1FF;
      ra = 5'($urandom); rb = 5'($urandom); n_ra = 3'($urandom); n_rb = 3'($urandom);
      step(1'b1);
    end
    rst = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h12345678; ra = 5'd3; rb = 5'd4;
    n_we = 1'b1; n_wa = 3'd3; n_ra = 3'd3; n_rb = 3'd4;
    step(1'b1);
    idle();
    for (int a = 0; a < 32; a++) begin
      ra = 5'(a); rb = 5'(a); n_ra = 3'(a); n_rb = 3'(a + 1);
      step(1'b1);
    end

    phase = "write_read";
    for (int i = 1; i < 32; i++) begin
      we = 1'b1; wa = 5'(i); wd = 32'h1000_0000 + 32'(i);
      n_we = (i < 8); n_wa = 3'(i); n_wd = 32'h1F0 + 32'(i);
      step(1'b1);
    end
    idle();
    for (int i = 1; i < 32; i++) begin
      ra = 5'(i); rb = 5'(32 - i); n_ra = 3'(i); n_rb = 3'(7 - i);
      step(1'b1);
    end

    phase = "zero_reg";
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; ra = 5'd0; rb = 5'd0;
    n_we = 1'b1; n_wa = 3'd0; n_wd = 32'h1FF; n_ra = 3'd0; n_rb = 3'd0;
    step(1'b1);
    idle();
    step(1'b1);

    phase = "bypass";
    we = 1'b1; wa = 5'd5; wd = 32'h11111111;
    n_we = 1'b1; n_wa = 3'd5; n_wd = 32'h11;
    step(1'b1);
    wd = 32'h22222222; ra = 5'd5; rb = 5'd6;
    n_wd = 32'h22; n_ra = 3'd5; n_rb = 3'd6;
    step(1'b1);
    idle();
    step(1'b1);

    phase = "rst_vs_write";
    rst = 1'b1; we = 1'b1; wa = 5'd7; wd = 32'hABCD0123; ra = 5'd7; rb = 5'd5;
    n_we = 1'b1; n_wa = 3'd7; n_wd = 32'h23; n_ra = 3'd7; n_rb = 3'd5;
    step(1'b1);
    idle();
    step(1'b1);

    phase = "random";
    for (int k = 0; k < 400; k++) begin
      rst  = ($urandom_range(0, 39) == 0);
      we   = 1'($urandom);
      wa   = 5'($urandom);
      wd   = $urandom;
      ra   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      rb   = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      n_we = 1'($urandom);
      n_wa = 3'($urandom);
      n_wd = $urandom;
      n_ra = ($urandom_range(0, 3) == 0) ? n_wa : 3'($urandom);
      n_rb = 3'($urandom);
      step(1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_2r1w.md
# regfile_2r1w

Parametrised register file: two read ports and one write port over DEPTH words of W bits, all in one clock domain. It generalises the team's single W-bit pipeline register into an addressable array. Optional features are a hard-wired zero register and same-cycle write-to-read bypass. It is the operand store feeding the ALU datapath: read ports drive ALU operands A and B, and the write port takes the ALU result.

## Interface
- W, 32, data width in bits (≥1)
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W words
- ZERO_REG, 1, 1: word 0 always reads 0 and ignores writes; 0: word 0 is an ordinary register
- BYPASS, 1, 1: a read of the address being written this cycle returns wr_data; 0: the read returns the stored (old) value

Ports:
- clk  input  1  sole clock; all state updates on posedge
- rst  input  1  synchronous, active-high reset
- wr_en  input  1  write enable, sampled on posedge clk
- wr_addr  input  ADDR_W  write address
- wr_data  input  W  write data
- rd_addr_a  input  ADDR_W  read port A address
- rd_data_a  output  W  read port A data (combinational)
- rd_addr_b  input  ADDR_W  read port B address
- rd_data_b  output  W  read port B data (combinational)

## Operation
- Storage: DEPTH × W flip-flops. No memory inference is required, because reset must clear every word.
- Write: at posedge clk, if rst=0 and wr_en=1, word[wr_addr] <= wr_data.
  - Exception: when ZERO_REG=1 and wr_addr=0, the write is discarded.
- Reset: at posedge clk with rst=1, every word <= 0. rst has priority over wr_en, so a write presented in the same cycle as reset is lost.
- Read (each port independent, identical logic):
  - If ZERO_REG=1 and rd_addr=0, data = 0.
  - Else, if BYPASS=1, wr_en=1, rst=0 and rd_addr=wr_addr, data = wr_data.
  - Else, data = word[rd_addr].
- Both ports may read the same address in the same cycle. Both return the same value.
- Bypass compares live (pre-edge) inputs only. It never forwards during rst=1.
- No handshake: wr_en is the only qualifier, and every asserted cycle is a write.
- Out-of-range addresses are impossible, since DEPTH = 2**ADDR_W exactly.

## Timing
- Write latency: data written at edge N is visible on a non-bypassed read after edge N (combinationally, within the same cycle that follows).
- Read latency: 0 cycles, combinational from rd_addr, stored words, and (when BYPASS=1) wr_en, wr_addr and wr_data.
- Reset values:
  - All words are 0 after the first posedge with rst=1.
  - rd_data_a and rd_data_b read 0 for every address from then until the first write.
- Before the first reset, contents are undefined (X in simulation). The bench must reset before checking.
- Reset mid-operation: a single rst=1 cycle clears all words regardless of prior writes. The next write is accepted on the first edge with rst=0.
- Back-to-back writes to the same address, one per cycle: each edge overwrites, and the last one wins.
- Critical path: rd_addr → DEPTH:1 mux → rd_data, plus the bypass compare/mux when BYPASS=1.

## Test plan
- Reset clear: write 0xDEADBEEF to words 1..31, assert rst 1 cycle → every address reads 0x00000000 on both ports.
- Write/read: write word[i] = 0x1000_0000+i for i=1..31 → port A reads all 31 values in order. Port B simultaneously reads addresses in reverse order and returns the matching values.
- Zero register (ZERO_REG=1): write 0xFFFFFFFF to addr 0 → both ports read 0 at addr 0. With ZERO_REG=0, the same write reads back 0xFFFFFFFF.
- Bypass (BYPASS=1): word 5 = 0x11111111; in one cycle present wr_en=1, wr_addr=5, wr_data=0x22222222 with rd_addr_a=5, rd_addr_b=6 → before the edge, A=0x22222222 and B=word 6. After the edge, A=0x22222222. With BYPASS=0, A=0x11111111 before the edge.
- Reset vs write collision: rst=1 and wr_en=1 (addr 7, 0xABCD0123) in the same cycle, bypass enabled, rd_addr_a=7 → A reads the stored value (no forward) during that cycle and 0 after the edge.
- Widths: rerun the write/read and reset scenarios with W=8, ADDR_W=3 → all 8 words behave correctly, and written data wraps modulo 2^8 (0x1FF written reads 0xFF).
